// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-128 control FSM and its round counter.
package ascon_pack;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_WAIT_AD = 3'd2,
    ST_AD      = 3'd3,
    ST_WAIT_PT = 3'd4,
    ST_PT      = 3'd5,
    ST_FINAL   = 3'd6,
    ST_DONE    = 3'd7
  } type_fsm_state;

  localparam logic [3:0] ROUNDS_A      = 4'd12;
  localparam logic [3:0] ROUND_B_START = 4'd6;
  localparam logic [3:0] ROUND_LAST    = ROUNDS_A - 4'd1;

endpackage

// File: rtl/round_counter.sv
// 4-bit permutation round index: load 0 (init_a), load 6 (init_b) or advance (en).
module round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       init_a_i,
  input  logic       init_b_i,
  input  logic       en_i,
  output logic [3:0] round_o
);

  logic [3:0] round_q, round_d;

  always_comb begin
    round_d = round_q;
    if (init_a_i)      round_d = 4'd0;
    else if (init_b_i) round_d = ROUND_B_START;
    else if (en_i)     round_d = round_q + 4'd1;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) round_q <= 4'd0;
    else         round_q <= round_d;
  end

  assign round_o = round_q;

endmodule

// File: rtl/ascon_fsm.sv
// Control FSM sequencing the ASCON-128 permutation datapath through one encryption.
// Define ASCON_FSM_DBG_EN to expose the current state on state_dbg_o.
module ascon_fsm
  import ascon_pack::*;
#(
  parameter int NB_AD = 1,
  parameter int NB_PT = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       select_o,
  output logic       en_reg_state_o,
  output logic       en_xor_data_b_o,
  output logic       en_xor_key_b_o,
  output logic       en_xor_key_e_o,
  output logic       en_xor_lsb_e_o,
  output logic [3:0] round_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       end_o
`ifdef ASCON_FSM_DBG_EN
  ,
  output logic [2:0] state_dbg_o
`endif
);

  localparam int NB_MAX = (NB_AD > NB_PT) ? NB_AD : NB_PT;
  localparam int BW     = $clog2(NB_MAX) + 1;
  localparam logic [BW-1:0] LAST_AD = BW'(NB_AD - 1);
  localparam logic [BW-1:0] LAST_PT = BW'(NB_PT - 1);
  localparam logic [BW-1:0] ONE     = BW'(1);

  type_fsm_state state_q, state_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          cipher_valid_q, tag_valid_q;
  logic          cnt_init_a, cnt_init_b, cnt_en;
  logic          pt_single;

  assign pt_single = (NB_PT == 1);

  round_counter u_round_counter (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .init_a_i (cnt_init_a),
    .init_b_i (cnt_init_b),
    .en_i     (cnt_en),
    .round_o  (round_o)
  );

  // Handshake: a block transfers in a cycle where data_ready_o and data_valid_i are both high;
  // data_ready_o depends on state only, never on data_valid_i.
  always_comb begin
    state_d         = state_q;
    blk_d           = blk_q;
    cnt_init_a      = 1'b0;
    cnt_init_b      = 1'b0;
    cnt_en          = 1'b0;
    data_ready_o    = 1'b0;
    select_o        = 1'b0;
    en_reg_state_o  = 1'b0;
    en_xor_data_b_o = 1'b0;
    en_xor_key_b_o  = 1'b0;
    en_xor_key_e_o  = 1'b0;
    en_xor_lsb_e_o  = 1'b0;
    en_cipher_o     = 1'b0;
    en_tag_o        = 1'b0;
    end_o           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_INIT;
          cnt_init_a = 1'b1;
          blk_d      = '0;
        end
      end
      ST_INIT: begin
        select_o       = (round_o != 4'd0);
        en_reg_state_o = 1'b1;
        cnt_en         = 1'b1;
        if (round_o == ROUND_LAST) begin
          en_xor_key_e_o = 1'b1;
          cnt_init_b     = 1'b1;
          blk_d          = '0;
          state_d        = ST_WAIT_AD;
        end
      end
      ST_WAIT_AD: begin
        select_o     = 1'b1;
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_reg_state_o  = 1'b1;
          en_xor_data_b_o = 1'b1;
          cnt_en          = 1'b1;
          state_d         = ST_AD;
        end
      end
      ST_AD: begin
        select_o       = 1'b1;
        en_reg_state_o = 1'b1;
        cnt_en         = 1'b1;
        if (round_o == ROUND_LAST) begin
          if (blk_q == LAST_AD) begin
            en_xor_lsb_e_o = 1'b1;
            blk_d          = '0;
            state_d        = ST_WAIT_PT;
            // The final plaintext block runs a full 12-round permutation, so park at 0.
            cnt_init_a     = pt_single;
            cnt_init_b     = !pt_single;
          end else begin
            blk_d      = blk_q + ONE;
            cnt_init_b = 1'b1;
            state_d    = ST_WAIT_AD;
          end
        end
      end
      ST_WAIT_PT: begin
        select_o     = 1'b1;
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_reg_state_o  = 1'b1;
          en_xor_data_b_o = 1'b1;
          en_cipher_o     = 1'b1;
          cnt_en          = 1'b1;
          if (blk_q == LAST_PT) begin
            en_xor_key_b_o = 1'b1;
            blk_d          = '0;
            state_d        = ST_FINAL;
          end else begin
            state_d = ST_PT;
          end
        end
      end
      ST_PT: begin
        select_o       = 1'b1;
        en_reg_state_o = 1'b1;
        cnt_en         = 1'b1;
        if (round_o == ROUND_LAST) begin
          blk_d      = blk_q + ONE;
          state_d    = ST_WAIT_PT;
          cnt_init_a = (blk_q + ONE == LAST_PT);
          cnt_init_b = (blk_q + ONE != LAST_PT);
        end
      end
      ST_FINAL: begin
        select_o       = 1'b1;
        en_reg_state_o = 1'b1;
        cnt_en         = 1'b1;
        if (round_o == ROUND_LAST) begin
          en_xor_key_e_o = 1'b1;
          en_tag_o       = 1'b1;
          cnt_init_a     = 1'b1;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: begin
        select_o = 1'b1;
        end_o    = 1'b1;
        if (start_i) begin
          state_d    = ST_INIT;
          cnt_init_a = 1'b1;
          blk_d      = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      blk_q          <= '0;
      cipher_valid_q <= 1'b0;
      tag_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      blk_q          <= blk_d;
      cipher_valid_q <= en_cipher_o;
      tag_valid_q    <= en_tag_o;
    end
  end

  assign cipher_valid_o = cipher_valid_q;
  assign tag_valid_o    = tag_valid_q;

`ifdef ASCON_FSM_DBG_EN
  assign state_dbg_o = state_q;
`endif

endmodule

// File: tb/tb_ascon_fsm.sv
// Scoreboard bench for ascon_fsm: default build (NB_AD=1, NB_PT=4) and an NB_AD=2, NB_PT=1 build.
module tb_ascon_fsm;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0 = 0;
  int   t1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT0: default parameters
  logic start0, valid0, ready0, sel0, enr0, xdb0, xkb0, xke0, lsb0, ci0, tg0, cv0, tv0, end0;
  logic [3:0] rnd0;
  // DUT1: two AD blocks, a single plaintext block
  logic start1, valid1, ready1, sel1, enr1, xdb1, xkb1, xke1, lsb1, ci1, tg1, cv1, tv1, end1;
  logic [3:0] rnd1;
`ifdef ASCON_FSM_DBG_EN
  logic [2:0] dbg0, dbg1;
`endif

  ascon_fsm u_dut0 (
    .clock_i(clk), .reset_i(rst), .start_i(start0), .data_valid_i(valid0),
    .data_ready_o(ready0), .select_o(sel0), .en_reg_state_o(enr0),
    .en_xor_data_b_o(xdb0), .en_xor_key_b_o(xkb0), .en_xor_key_e_o(xke0),
    .en_xor_lsb_e_o(lsb0), .round_o(rnd0), .en_cipher_o(ci0), .en_tag_o(tg0),
    .cipher_valid_o(cv0), .tag_valid_o(tv0), .end_o(end0)
`ifdef ASCON_FSM_DBG_EN
    , .state_dbg_o(dbg0)
`endif
  );

  ascon_fsm #(.NB_AD(2), .NB_PT(1)) u_dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(start1), .data_valid_i(valid1),
    .data_ready_o(ready1), .select_o(sel1), .en_reg_state_o(enr1),
    .en_xor_data_b_o(xdb1), .en_xor_key_b_o(xkb1), .en_xor_key_e_o(xke1),
    .en_xor_lsb_e_o(lsb1), .round_o(rnd1), .en_cipher_o(ci1), .en_tag_o(tg1),
    .cipher_valid_o(cv1), .tag_valid_o(tv1), .end_o(end1)
`ifdef ASCON_FSM_DBG_EN
    , .state_dbg_o(dbg1)
`endif
  );

  logic [15:0] obs0, obs1;
  assign obs0 = {sel0, enr0, xdb0, xkb0, xke0, lsb0, rnd0, ci0, tg0, cv0, tv0, end0, ready0};
  assign obs1 = {sel1, enr1, xdb1, xkb1, xke1, lsb1, rnd1, ci1, tg1, cv1, tv1, end1, ready1};

  // Event word: {cycle offset from start (8b), output vector (16b)}
  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] o_of(bit sel, bit en, bit xdb, bit xkb, bit xke, bit lsb,
                                       int rnd, bit ci, bit tg, bit cv, bit tv, bit e, bit rdy);
    logic [3:0] r;
    r = 4'(rnd);
    return {sel, en, xdb, xkb, xke, lsb, r, ci, tg, cv, tv, e, rdy};
  endfunction

  function automatic logic [23:0] ev(int rel, logic [15:0] o);
    logic [7:0] r;
    r = 8'(rel);
    return {r, o};
  endfunction

  task automatic push0(input int rel, input logic [15:0] o);
    exp_q0.push_back(ev(rel, o));
  endtask

  task automatic push1(input int rel, input logic [15:0] o);
    exp_q1.push_back(ev(rel, o));
  endtask

  // Monitors: any cycle with a datapath-affecting strobe, a valid pulse or a stalled wait is an event
  always @(negedge clk) begin
    logic trig;
    trig = xdb0 | xkb0 | xke0 | lsb0 | ci0 | tg0 | cv0 | tv0 | (enr0 & ~sel0) | (ready0 & ~valid0);
    if (trig) begin
      if (exp_q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event_dut0: got %h expected none", ev(cyc - t0, obs0));
      end else begin
        check("event_dut0", 32'(ev(cyc - t0, obs0)), 32'(exp_q0.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    logic trig;
    trig = xdb1 | xkb1 | xke1 | lsb1 | ci1 | tg1 | cv1 | tv1 | (enr1 & ~sel1) | (ready1 & ~valid1);
    if (trig) begin
      if (exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event_dut1: got %h expected none", ev(cyc - t1, obs1));
      end else begin
        check("event_dut1", 32'(ev(cyc - t1, obs1)), 32'(exp_q1.pop_front()));
      end
    end
  end

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start0();
    @(posedge clk);
    #1;
    t0 = cyc;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
  endtask

  // Expected trace of a full NB_AD=1/NB_PT=4 encryption; 'stall' idle cycles before PT block 1.
  task automatic push_main_run(input int stall);
    push0(1,  o_of(0,1,0,0,0,0,0,  0,0,0,0,0,0));
    push0(12, o_of(1,1,0,0,1,0,11, 0,0,0,0,0,0));
    push0(13, o_of(1,1,1,0,0,0,6,  0,0,0,0,0,1));
    push0(18, o_of(1,1,0,0,0,1,11, 0,0,0,0,0,0));
    push0(19, o_of(1,1,1,0,0,0,6,  1,0,0,0,0,1));
    push0(20, o_of(1,1,0,0,0,0,7,  0,0,1,0,0,0));
    for (int i = 0; i < stall; i++) push0(25 + i, o_of(1,0,0,0,0,0,6, 0,0,0,0,0,1));
    push0(25 + stall, o_of(1,1,1,0,0,0,6,  1,0,0,0,0,1));
    push0(26 + stall, o_of(1,1,0,0,0,0,7,  0,0,1,0,0,0));
    push0(31 + stall, o_of(1,1,1,0,0,0,6,  1,0,0,0,0,1));
    push0(32 + stall, o_of(1,1,0,0,0,0,7,  0,0,1,0,0,0));
    push0(37 + stall, o_of(1,1,1,1,0,0,0,  1,0,0,0,0,1));
    push0(38 + stall, o_of(1,1,0,0,0,0,1,  0,0,1,0,0,0));
    push0(48 + stall, o_of(1,1,0,0,1,0,11, 0,1,0,0,0,0));
    push0(49 + stall, o_of(1,0,0,0,0,0,0,  0,0,0,1,1,0));
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; valid0 = 1'b1;
    start1 = 1'b0; valid1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs_dut0", 32'(obs0), 32'h0);
    check("reset_outputs_dut1", 32'(obs1), 32'h0);
`ifdef ASCON_FSM_DBG_EN
    check("reset_state_dut0", 32'(dbg0), 32'd0);
`endif

    // Reset in the middle of INIT
    push0(1, o_of(0,1,0,0,0,0,0, 0,0,0,0,0,0));
    pulse_start0();
    wait_to(t0 + 6);
    check("round_before_reset", 32'(rnd0), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_init", 32'(obs0), 32'h0);
`ifdef ASCON_FSM_DBG_EN
    check("reset_mid_state", 32'(dbg0), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full run, valid held high, stray start during AD
    push_main_run(0);
    pulse_start0();
    wait_to(t0 + 15);
    start0 = 1'b1;
    wait_to(t0 + 16);
    start0 = 1'b0;
    wait_to(t0 + 55);
    check("end_level_run1", 32'(end0), 32'd1);

    // Restart from DONE with a 3-cycle stall in WAIT_PT
    push_main_run(3);
    pulse_start0();
    wait_to(t0 + 25);
    valid0 = 1'b0;
    wait_to(t0 + 28);
    valid0 = 1'b1;
    wait_to(t0 + 58);
    check("end_level_run2", 32'(end0), 32'd1);

    // NB_AD=2, NB_PT=1
    push1(1,  o_of(0,1,0,0,0,0,0,  0,0,0,0,0,0));
    push1(12, o_of(1,1,0,0,1,0,11, 0,0,0,0,0,0));
    push1(13, o_of(1,1,1,0,0,0,6,  0,0,0,0,0,1));
    push1(19, o_of(1,1,1,0,0,0,6,  0,0,0,0,0,1));
    push1(24, o_of(1,1,0,0,0,1,11, 0,0,0,0,0,0));
    push1(25, o_of(1,1,1,1,0,0,0,  1,0,0,0,0,1));
    push1(26, o_of(1,1,0,0,0,0,1,  0,0,1,0,0,0));
    push1(36, o_of(1,1,0,0,1,0,11, 0,1,0,0,0,0));
    push1(37, o_of(1,0,0,0,0,0,0,  0,0,0,1,1,0));
    @(posedge clk);
    #1;
    t1 = cyc;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    wait_to(t1 + 45);
    check("end_level_dut1", 32'(end1), 32'd1);

    @(negedge clk);
    check("pending_events_dut0", 32'(exp_q0.size()), 32'd0);
    check("pending_events_dut1", 32'(exp_q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
